// File: rtl/mmio_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_initiator
//  Description : Command-driven initiator for the FPRO MMIO bus. Commands
//                arrive on a valid/ready port and are queued in a small FIFO.
//                Each one becomes a single-cycle FPRO transaction (mmio_cs
//                with mmio_rd or mmio_wr). Exactly one response per command
//                is returned on a valid/ready port.
//  Optional    : `define MMIO_POLL_EN enables poll commands. A poll re-reads
//                an address until (rd & mask) == (value & mask), or until
//                POLL_LIMIT reads have mismatched.
//  Ports       : clk, rst (asynchronous, active low)
//                cmd_*  : command port (valid/ready, wr, addr, data, poll, mask)
//                rsp_*  : response port (valid/ready, data, wr echo, timeout)
//                mmio_* : FPRO bus (registered cs/wr/rd/addr/wr_data,
//                         combinational rd_data)
//                busy   : FSM not idle, or commands still queued
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_bus_initiator #(
    parameter int CMD_DEPTH  = 4,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [20:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_poll,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic        rsp_timeout,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);
    localparam int            c_AW    = $clog2(CMD_DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(CMD_DEPTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUS  = 2'd1;
`ifdef MMIO_POLL_EN
    localparam logic [1:0] c_S_CHK  = 2'd2;
`endif
    localparam logic [1:0] c_S_RESP = 2'd3;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [20:0]     r_fifo_addr [CMD_DEPTH];
    logic [31:0]     r_fifo_data [CMD_DEPTH];
    logic            r_fifo_wr   [CMD_DEPTH];
`ifdef MMIO_POLL_EN
    logic            r_fifo_poll [CMD_DEPTH];
    logic [31:0]     r_fifo_mask [CMD_DEPTH];
`endif
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_not_empty;
    logic            w_push;
    logic            w_pop;

    // Ready comes only from the registered count. It is forced low while
    // reset is held.
    assign cmd_ready = rst & (r_count != c_DEPTH);
    assign w_push    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cmd_addr;
            r_fifo_data[r_wptr] <= cmd_data;
            r_fifo_wr[r_wptr]   <= cmd_wr;
`ifdef MMIO_POLL_EN
            r_fifo_poll[r_wptr] <= cmd_poll;
            r_fifo_mask[r_wptr] <= cmd_mask;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The pop side sees a new entry one cycle after it is written.
            // This gives the command-to-bus latency of two edges. A
            // continuously non-empty queue still sustains one command
            // every three cycles.
            r_not_empty <= (r_count != '0);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_start;
    logic       w_start_wr;
    logic       w_to_resp;
    logic       w_rsp_done;

`ifdef MMIO_POLL_EN
    localparam int              c_PW      = $clog2(POLL_LIMIT + 1);
    localparam logic [c_PW-1:0] c_PLIM_M1 = c_PW'(POLL_LIMIT - 1);
    logic            r_cur_poll;
    logic [31:0]     r_cur_mask;
    logic [c_PW-1:0] r_attempts;
    logic            w_match;
    logic            w_limit;
    logic            r_timeout;

    // During a poll, mmio_wr_data still holds the compare value and
    // rsp_data holds the latest read.
    assign w_match     = (((rsp_data ^ mmio_wr_data) & r_cur_mask) == '0);
    assign w_limit     = (r_attempts == c_PLIM_M1);
    assign rsp_timeout = r_timeout;
`else
    logic w_unused;
    assign w_unused    = &{1'b0, cmd_poll, cmd_mask, (POLL_LIMIT > 0)};
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: if (r_not_empty && (r_count != '0) && !rsp_valid) w_next = c_S_BUS;
`ifdef MMIO_POLL_EN
            c_S_BUS:  w_next = r_cur_poll ? c_S_CHK : c_S_RESP;
            c_S_CHK:  w_next = (w_match || w_limit) ? c_S_RESP : c_S_BUS;
`else
            c_S_BUS:  w_next = c_S_RESP;
`endif
            c_S_RESP: if (rsp_valid && rsp_ready) w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = (w_next == c_S_BUS);
        w_pop      = (r_state == c_S_IDLE) && w_start;
        w_start_wr = w_pop && r_fifo_wr[r_rptr];
        w_to_resp  = (r_state != c_S_RESP) && (w_next == c_S_RESP);
        w_rsp_done = (r_state == c_S_RESP) && (w_next == c_S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registered bus and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_wr       <= 1'b0;
`ifdef MMIO_POLL_EN
            r_cur_poll   <= 1'b0;
            r_cur_mask   <= '0;
            r_attempts   <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            mmio_cs <= w_start;
            mmio_wr <= w_start_wr;
            mmio_rd <= w_start & ~w_start_wr;
            if (w_pop) begin
                mmio_addr    <= r_fifo_addr[r_rptr];
                mmio_wr_data <= r_fifo_data[r_rptr];
                rsp_wr       <= r_fifo_wr[r_rptr];
`ifdef MMIO_POLL_EN
                // A poll flag on a write is ignored.
                r_cur_poll   <= r_fifo_poll[r_rptr] & ~r_fifo_wr[r_rptr];
                r_cur_mask   <= r_fifo_mask[r_rptr];
                r_attempts   <= '0;
                r_timeout    <= 1'b0;
`endif
            end
            // Read data is captured at the edge that closes the bus cycle.
            if (r_state == c_S_BUS) rsp_data <= mmio_wr ? 32'd0 : mmio_rd_data;
`ifdef MMIO_POLL_EN
            if ((r_state == c_S_CHK) && !w_match) begin
                if (w_limit) r_timeout  <= 1'b1;
                else         r_attempts <= r_attempts + 1'b1;
            end
`endif
            if (w_to_resp)       rsp_valid <= 1'b1;
            else if (w_rsp_done) rsp_valid <= 1'b0;
        end
    end

    assign busy = (r_state != c_S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_bus_initiator
//  Description : Self-checking bench for mmio_bus_initiator. Expected bus
//                operations and responses are queued when commands are
//                accepted and compared when the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_bus_initiator;
    localparam int CMD_DEPTH  = 4;
    localparam int POLL_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [20:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_poll = 1'b0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_timeout;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;

    always #5 clk = ~clk;

    mmio_bus_initiator #(.CMD_DEPTH(CMD_DEPTH), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_poll(cmd_poll), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .busy(busy)
    );

    typedef struct packed {
        logic        wr;
        logic [20:0] addr;
        logic [31:0] data;
        logic [15:0] n;
    } bus_t;
    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic        to;
    } rsp_t;

    bus_t        exp_bus[$];
    rsp_t        exp_rsp[$];
    logic [31:0] bus_q[$];
    logic [31:0] bus_head = '0;
    logic [31:0] bus_dflt = '0;
    int          cs_hist[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cs_pulses = 0;
    int   rsp_count = 0;
    int   last_cs_cyc = -1;
    int   last_rise_cyc = -1;
    int   acc_cyc = 0;
    logic prev_cs = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave model: the read value is presented from mid-cycle of each read.
    always @(negedge clk) begin
        if (mmio_cs && mmio_rd) begin
            if (bus_q.size() != 0) bus_head = bus_q.pop_front();
            else                   bus_head = bus_dflt;
        end
    end
    assign mmio_rd_data = (mmio_cs && mmio_rd) ? bus_head : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus and response monitor.
    always @(negedge clk) begin
        bus_t b;
        rsp_t r;
        if (rst) begin
            if (mmio_cs) begin
                cs_pulses++;
                last_cs_cyc = cyc;
                cs_hist.push_back(cyc);
                chk("cs_back_to_back", prev_cs, 1'b0);
                chk("rd_xor_wr", mmio_rd ^ mmio_wr, 1'b1);
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL bus_unexpected observed addr=%0h expected no cycle", mmio_addr);
                end else begin
                    b = exp_bus[0];
                    chk("bus_wr", mmio_wr, b.wr);
                    chk("bus_addr", mmio_addr, b.addr);
                    chk("bus_wdata", mmio_wr_data, b.data);
                    b.n = b.n - 16'd1;
                    if (b.n == 16'd0) void'(exp_bus.pop_front());
                    else              exp_bus[0] = b;
                end
            end
            if (rsp_valid && !prev_valid) last_rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rsp_unexpected observed data=%0h expected none", rsp_data);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_wr", rsp_wr, r.wr);
                    chk("rsp_data", rsp_data, r.data);
                    chk("rsp_timeout", rsp_timeout, r.to);
                end
            end
        end
        prev_cs    = mmio_cs;
        prev_valid = rsp_valid;
    end

    // Offer one command and wait (bounded) for it to be accepted.
    task automatic send(input logic wr, input logic [20:0] addr, input logic [31:0] data,
                        input logic poll, input logic [31:0] mask, input logic [15:0] nrd,
                        input logic [31:0] rdata, input logic to);
        int   n = 0;
        bus_t b;
        rsp_t r;
        cmd_wr = wr; cmd_addr = addr; cmd_data = data; cmd_poll = poll; cmd_mask = mask;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        if (n < 200) begin
            b.wr = wr; b.addr = addr; b.data = data; b.n = nrd;
            r.wr = wr; r.data = wr ? 32'd0 : rdata; r.to = to;
            exp_bus.push_back(b);
            exp_rsp.push_back(r);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rsp.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 300), 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int r0;
        int k;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", mmio_cs, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single write
        p0 = cs_pulses;
        send(1'b1, 21'h00080, 32'h0000_00A5, 1'b0, 32'h0, 16'd1, 32'h0, 1'b0);
        k = acc_cyc;
        drain();
        chk("wr_cs_pulses", cs_pulses - p0, 1);
        chk("wr_cs_cycle", last_cs_cyc, k + 2);

        // Single read, latency
        bus_q.push_back(32'h1234_5678);
        send(1'b0, 21'h000C0, 32'h0, 1'b0, 32'h0, 16'd1, 32'h1234_5678, 1'b0);
        k = acc_cyc;
        drain();
        chk("rd_cs_cycle", last_cs_cyc, k + 2);
        chk("rd_rsp_rise", last_rise_cyc, k + 3);

        // Streaming throughput, rsp_ready tied high
        cs_hist.delete();
        for (int i = 0; i < 4; i++)
            send(1'b1, 21'h00040 + 21'(i), 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 16'd1, 32'h0, 1'b0);
        drain();
        chk("stream_cs_count", cs_hist.size(), 4);
        for (int i = 1; i < 4; i++) chk("stream_spacing", cs_hist[i] - cs_hist[i-1], 3);

        // Back-pressure: five commands against a four-entry FIFO
        rsp_ready = 1'b0;
        p0 = cs_pulses;
        r0 = rsp_count;
        for (int i = 0; i < 5; i++) begin
            logic w;
            w = i[0];
            if (!w) bus_q.push_back(32'hB0B0_0000 + 32'(i));
            send(w, 21'h00100 + 21'(i), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, 16'd1,
                 32'hB0B0_0000 + 32'(i), 1'b0);
        end
        repeat (6) @(negedge clk);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        chk("bp_cs_pulses", cs_pulses - p0, 1);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();
        repeat (4) @(negedge clk);
        chk("bp_total_cs", cs_pulses - p0, 5);
        chk("bp_total_rsp", rsp_count - r0, 5);
        @(posedge clk);
        #1;

        // Reset during a bus cycle
        bus_q.push_back(32'hFFFF_0000);
        send(1'b0, 21'h001F0, 32'h0, 1'b0, 32'h0, 16'd1, 32'hFFFF_0000, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!mmio_cs && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("rst_mid_saw_cs", mmio_cs, 1'b1);
        end
        rst = 1'b0;
        #1;
        chk("rst_mid_cs_drop", mmio_cs, 1'b0);
        chk("rst_mid_rd_drop", mmio_rd, 1'b0);
        chk("rst_mid_addr", mmio_addr, 21'h0);
        exp_bus.delete();
        exp_rsp.delete();
        bus_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        p0 = cs_pulses;
        r0 = rsp_count;
        @(negedge clk);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_count - r0, 0);
        chk("rst_mid_no_cs", cs_pulses - p0, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        send(1'b1, 21'h00011, 32'h5A5A_5A5A, 1'b0, 32'h0, 16'd1, 32'h0, 1'b0);
        drain();

`ifdef MMIO_POLL_EN
        // Poll that matches on the third read
        bus_q.push_back(32'h0);
        bus_q.push_back(32'h0);
        bus_q.push_back(32'h1);
        p0 = cs_pulses;
        send(1'b0, 21'h00200, 32'h1, 1'b1, 32'h1, 16'd3, 32'h1, 1'b0);
        drain();
        chk("poll_reads", cs_pulses - p0, 3);

        // Poll that never matches
        bus_dflt = 32'h0;
        p0 = cs_pulses;
        send(1'b0, 21'h00204, 32'h1, 1'b1, 32'h1, 16'(POLL_LIMIT), 32'h0, 1'b1);
        drain();
        chk("poll_timeout_reads", cs_pulses - p0, POLL_LIMIT);

        // Poll flag on a write executes as a plain write
        p0 = cs_pulses;
        send(1'b1, 21'h00208, 32'h55, 1'b1, 32'hFF, 16'd1, 32'h0, 1'b0);
        drain();
        chk("poll_wr_plain", cs_pulses - p0, 1);
`endif

        chk("final_exp_bus_empty", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_bus_initiator.md
Name: mmio_bus_initiator

Overview:
- Command-driven master for the FPRO MMIO bus. It is the initiator end of the interface that mmio_sys_vanilla responds on.
- Accepts read/write commands through a valid/ready port and buffers them in a small FIFO.
- Issues single-cycle FPRO transactions: mmio_cs with mmio_rd or mmio_wr.
- Returns one response per command through a valid/ready port.
- Used as a test/debug bus master or a bridge-side sequencer alongside the processor port.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of 2, at least 2.
- POLL_LIMIT, 1024: maximum read attempts for a poll command (used only with MMIO_POLL_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  21  FPRO word address.
- cmd_data  in  32  write data; poll compare value when polling.
- cmd_poll  in  1  poll request (MMIO_POLL_EN only).
- cmd_mask  in  32  poll compare mask (MMIO_POLL_EN only).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data; 0 for writes.
- rsp_wr  out  1  echo of the command type.
- rsp_timeout  out  1  poll gave up (MMIO_POLL_EN only).
- mmio_cs  out  1  FPRO chip select.
- mmio_wr  out  1  FPRO write strobe.
- mmio_rd  out  1  FPRO read strobe.
- mmio_addr  out  21  FPRO address.
- mmio_wr_data  out  32  FPRO write data.
- mmio_rd_data  in  32  FPRO read data; combinational from the bus, valid in the same cycle as cs/rd.
- busy  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0 and FIFO flushed. This includes mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, rsp_valid, rsp_data and rsp_timeout. cmd_ready=0 while rst=0 and 1 on the first cycle after release. A bus cycle in flight is aborted with no response.
- FIFO: push on cmd_valid && cmd_ready. cmd_ready = !full, taken from the registered count, so a push offered while full is ignored. A push and a pop in the same cycle leave the count unchanged. Order is strictly FIFO.
- All mmio_* outputs are registered. Outside the BUS state, cs/wr/rd=0 and addr/wr_data hold their last values.
- FSM states: IDLE, BUS, CHK, RESP.
  - IDLE: if the FIFO is not empty and rsp_valid=0, pop and load mmio_addr/mmio_wr_data, then go to BUS. Otherwise stay.
  - BUS: mmio_cs=1 plus exactly one of mmio_rd or mmio_wr, for exactly one cycle.
    - On a read, mmio_rd_data is captured at the closing edge into rsp_data.
    - On a write, rsp_data=0.
    - Next state is RESP, or CHK for a poll.
  - CHK: poll compare only (see Optional Feature).
  - RESP: rsp_valid=1, and rsp_data/rsp_wr/rsp_timeout are stable. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- Latency:
  - Command accepted at edge k puts mmio_cs high in the cycle after edge k+2 when the FIFO was empty and the FSM idle.
  - rsp_valid rises at edge k+3.
  - With rsp_ready tied high, one transaction completes per 3 cycles.
- Back-pressure: while rsp_ready=0 the FSM stays in RESP, no new bus cycle starts, and the FIFO fills until cmd_ready=0.
- mmio_cs is never asserted for two consecutive cycles. mmio_rd and mmio_wr are never asserted together.

Optional Feature:
- Macro: MMIO_POLL_EN.
- With the macro defined, a command with cmd_poll=1 and cmd_wr=0 becomes a poll:
  - BUS performs a read, then CHK compares (rd & cmd_mask) == (cmd_data & cmd_mask).
  - On a match, go to RESP with rsp_data = the matching read and rsp_timeout=0.
  - On a mismatch, increment the attempt counter and return to BUS.
  - After POLL_LIMIT mismatched reads, go to RESP with rsp_timeout=1 and rsp_data = the last read.
  - Poll reads are spaced 2 cycles apart (BUS, CHK).
  - A command with cmd_poll=1 and cmd_wr=1 executes as a plain write.
  - The FIFO stores poll and mask per entry.
- Without the macro: cmd_poll and cmd_mask are ignored and not stored, rsp_timeout is tied to 0, and the CHK state is absent.

Test Plan:
- Write 0x0000_00A5 to addr 0x00080, rsp_ready=1 -> exactly one cycle with mmio_cs=1, mmio_wr=1, mmio_addr=0x00080, mmio_wr_data=0xA5; then rsp_valid with rsp_wr=1 and rsp_data=0.
- Read addr 0x000C0 with the bus model returning 0x1234_5678 while cs&rd -> rsp_data=0x1234_5678, rsp_wr=0; rsp_valid at edge k+3.
- rsp_ready=0, push 5 commands with CMD_DEPTH=4 -> 1 executes and 4 are buffered, then cmd_ready=0. Release rsp_ready -> all 5 responses in order, no extra mmio_cs pulses.
- Assert rst low during a BUS cycle -> mmio_cs drops immediately, no response, and after release the FIFO is empty and busy=0.
- MMIO_POLL_EN: poll with mask 0x1 and value 0x1, bus returning 0,0,1 -> 3 mmio_rd pulses, rsp_data=1, rsp_timeout=0.
- MMIO_POLL_EN with POLL_LIMIT=8 and a bus that always returns 0 -> exactly 8 reads, then rsp_timeout=1.
